window_spill_fill: RTL and testbench

- Register-window manager that sits directly upstream of the windowed register file.
- Owns CWP and WIM and drives the register file's window select.
- On SAVE/RESTORE that would enter an invalid window, it autonomously spills 16 registers (locals r16-r23, ins r24-r31) to memory or fills them from memory, then commits the window move.

---
 rtl/window_spill_fill_pkg.sv | 34 +++
 rtl/window_spill_fill_wim_rotator.sv | 15 +
 rtl/window_spill_fill.sv | 176 +++++++++++++++++
 tb/tb_window_spill_fill.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_spill_fill_pkg.sv
// rtl/window_spill_fill_pkg.sv - shared states, constants and WIM rotate helpers
package window_spill_fill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SP_RD,
    SP_MEM,
    FL_MEM,
    FL_WR,
    COMMIT
  } state_t;

  localparam int REG_LOCAL_BASE = 16;
  localparam int SPILL_COUNT    = 16;
  localparam int MAX_WIN        = 32;

  // Rotate the low n bits of w by one position; bits at n and above stay zero.
  function automatic logic [MAX_WIN-1:0] wim_rotl(input logic [MAX_WIN-1:0] w, input int n);
    logic [MAX_WIN-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_WIN; k++)
      if (k < n) r[(k + 1) % n] = w[k];
    return r;
  endfunction

  function automatic logic [MAX_WIN-1:0] wim_rotr(input logic [MAX_WIN-1:0] w, input int n);
    logic [MAX_WIN-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_WIN; k++)
      if (k < n) r[(k + n - 1) % n] = w[k];
    return r;
  endfunction

endpackage

// File: rtl/window_spill_fill_wim_rotator.sv
// rtl/window_spill_fill_wim_rotator.sv - combinational one-step WIM rotate with NWIN wrap
module wim_rotator
  import window_spill_fill_pkg::*;
#(
  parameter int NWIN = 4
) (
  input  logic [NWIN-1:0] wim_i,
  output logic [NWIN-1:0] rotl_o,
  output logic [NWIN-1:0] rotr_o
);

  assign rotl_o = NWIN'(wim_rotl(MAX_WIN'(wim_i), NWIN));
  assign rotr_o = NWIN'(wim_rotr(MAX_WIN'(wim_i), NWIN));

endmodule

// File: rtl/window_spill_fill.sv
// rtl/window_spill_fill.sv - register-window manager with autonomous spill/fill
// Optional SpillCnt/FillCnt outputs under WINDOW_SPILL_FILL_STATS_EN.
module window_spill_fill
  import window_spill_fill_pkg::*;
#(
  parameter int NWIN   = 4,
  parameter int WIN_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Save,
  input  logic              Restore,
  input  logic [31:0]       SpBase,
  output logic              Busy,
  output logic              Done,
  output logic [WIN_W-1:0]  CWP,
  output logic [NWIN-1:0]   WIM,
  output logic [WIN_W-1:0]  RfCwp,
  output logic [4:0]        RfRA,
  input  logic [DATA_W-1:0] RfAout,
  output logic [4:0]        RfRC,
  output logic [DATA_W-1:0] RfRin,
  output logic              RfRFE,
  output logic              MemReq,
  output logic              MemWe,
  output logic [31:0]       MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck
`ifdef WINDOW_SPILL_FILL_STATS_EN
  ,
  output logic [15:0]       SpillCnt,
  output logic [15:0]       FillCnt
`endif
);

  state_t              state_q, state_d;
  logic [WIN_W-1:0]    cwp_q, cwp_d, nw_q, nw_d, nw_req;
  logic [NWIN-1:0]     wim_q, wim_d, wim_rotl, wim_rotr;
  logic [3:0]          i_q, i_d;
  logic                op_save_q, op_save_d;
  logic [31:0]         base_q, base_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic                req_ok, last_reg;
  logic [4:0]          reg_idx;

  wim_rotator #(.NWIN(NWIN)) u_wim_rotator (
    .wim_i  (wim_q),
    .rotl_o (wim_rotl),
    .rotr_o (wim_rotr)
  );

  // Simultaneous Save and Restore is treated as no request at all.
  assign req_ok   = Save ^ Restore;
  assign nw_req   = Save ? cwp_q - WIN_W'(1) : cwp_q + WIN_W'(1);
  assign last_reg = (i_q == 4'(SPILL_COUNT - 1));
  assign reg_idx  = 5'(REG_LOCAL_BASE) + {1'b0, i_q};

  always_comb begin
    state_d   = state_q;
    cwp_d     = cwp_q;
    wim_d     = wim_q;
    nw_d      = nw_q;
    i_d       = i_q;
    op_save_d = op_save_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          if (!wim_q[nw_req]) begin
            cwp_d = nw_req;
          end else begin
            nw_d      = nw_req;
            op_save_d = Save;
            base_d    = SpBase;
            i_d       = '0;
            state_d   = Save ? SP_RD : FL_MEM;
          end
        end
      end
      SP_RD: begin
        wdata_d = RfAout;
        state_d = SP_MEM;
      end
      SP_MEM: begin
        if (MemAck) begin
          if (last_reg) state_d = COMMIT;
          else begin
            i_d     = i_q + 4'd1;
            state_d = SP_RD;
          end
        end
      end
      FL_MEM: begin
        if (MemAck) begin
          rdata_d = MemRData;
          state_d = FL_WR;
        end
      end
      FL_WR: begin
        if (last_reg) state_d = COMMIT;
        else begin
          i_d     = i_q + 4'd1;
          state_d = FL_MEM;
        end
      end
      COMMIT: begin
        cwp_d   = nw_q;
        wim_d   = op_save_q ? wim_rotr : wim_rotl;
        i_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q   <= IDLE;
      cwp_q     <= '0;
      wim_q     <= {1'b1, {(NWIN-1){1'b0}}};
      nw_q      <= '0;
      i_q       <= '0;
      op_save_q <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cwp_q     <= cwp_d;
      wim_q     <= wim_d;
      nw_q      <= nw_d;
      i_q       <= i_d;
      op_save_q <= op_save_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Fast-path Done is combinational so a valid-window move costs no stall.
  assign Done     = (state_q == COMMIT) || (state_q == IDLE && req_ok && !wim_q[nw_req]);
  assign Busy     = (state_q != IDLE);
  assign CWP      = cwp_q;
  assign WIM      = wim_q;
  assign RfCwp    = Busy ? nw_q : cwp_q;
  assign RfRA     = (state_q == SP_RD) ? reg_idx : 5'd0;
  assign RfRC     = (state_q == FL_WR) ? reg_idx : 5'd0;
  assign RfRin    = (state_q == FL_WR) ? rdata_q : '0;
  assign RfRFE    = (state_q != FL_WR);
  assign MemReq   = (state_q == SP_MEM) || (state_q == FL_MEM);
  assign MemWe    = (state_q == SP_MEM);
  assign MemAddr  = MemReq ? base_q + {26'd0, i_q, 2'b00} : 32'd0;
  assign MemWData = wdata_q;

`ifdef WINDOW_SPILL_FILL_STATS_EN
  logic [15:0] spill_cnt_q, fill_cnt_q;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      spill_cnt_q <= '0;
      fill_cnt_q  <= '0;
    end else if (state_q == COMMIT) begin
      if (op_save_q && spill_cnt_q != 16'hFFFF) spill_cnt_q <= spill_cnt_q + 16'd1;
      if (!op_save_q && fill_cnt_q != 16'hFFFF) fill_cnt_q <= fill_cnt_q + 16'd1;
    end
  end

  assign SpillCnt = spill_cnt_q;
  assign FillCnt  = fill_cnt_q;
`endif

endmodule

// File: tb/tb_window_spill_fill.sv
// tb/tb_window_spill_fill.sv - randomized scoreboard bench for window_spill_fill
module tb_window_spill_fill;

  logic        Clk = 1'b0;
  logic        Clr, Save, Restore, MemAck;
  logic [31:0] SpBase, RfAout, MemRData;
  logic        Busy, Done, RfRFE, MemReq, MemWe;
  logic [1:0]  CWP, RfCwp;
  logic [3:0]  WIM;
  logic [4:0]  RfRA, RfRC;
  logic [31:0] RfRin, MemAddr, MemWData;
`ifdef WINDOW_SPILL_FILL_STATS_EN
  logic [15:0] SpillCnt, FillCnt;
`endif

  window_spill_fill dut (
    .Clk(Clk), .Clr(Clr), .Save(Save), .Restore(Restore), .SpBase(SpBase),
    .Busy(Busy), .Done(Done), .CWP(CWP), .WIM(WIM), .RfCwp(RfCwp),
    .RfRA(RfRA), .RfAout(RfAout), .RfRC(RfRC), .RfRin(RfRin), .RfRFE(RfRFE),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
`ifdef WINDOW_SPILL_FILL_STATS_EN
    , .SpillCnt(SpillCnt), .FillCnt(FillCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_exp_t;
  typedef struct { int win; int rno; logic [31:0] data; } wr_exp_t;
  typedef struct { int cwp; int wim; } cmt_exp_t;

  mem_exp_t mem_q[$];
  wr_exp_t  wr_q[$];
  cmt_exp_t cmt_q[$];
  cmt_exp_t pend;
  bit       pend_v = 0;

  logic [31:0] rf_dut [0:3][0:15];
  logic [31:0] rf_ref [0:3][0:15];
  int checks = 0, errors = 0;
  int m_cwp, m_inv, fill_epoch = 0, n_acks = 0;

  assign RfAout = rf_dut[RfCwp][RfRA[3:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] fill_val(input logic [31:0] addr, input int epoch);
    return 32'hA000_0000 ^ (addr << 4) ^ 32'(epoch);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: windows are positions on a ring of 4, exactly one invalid.
  task automatic model_issue(input bit s, input bit r, input logic [31:0] base, output int kind);
    int nw;
    kind = 0;
    if (s == r) return;
    nw = s ? (m_cwp + 3) % 4 : (m_cwp + 1) % 4;
    if (nw != m_inv) begin
      kind = 1;
      cmt_q.push_back('{nw, 1 << m_inv});
    end else if (s) begin
      kind = 2;
      for (int i = 0; i < 16; i++) mem_q.push_back('{1'b1, base + 32'(4 * i), rf_ref[nw][i]});
      m_inv = (nw + 3) % 4;
      cmt_q.push_back('{nw, 1 << m_inv});
    end else begin
      kind = 3;
      fill_epoch++;
      for (int i = 0; i < 16; i++) begin
        logic [31:0] a;
        a = base + 32'(4 * i);
        mem_q.push_back('{1'b0, a, 32'd0});
        wr_q.push_back('{nw, 16 + i, fill_val(a, fill_epoch)});
        rf_ref[nw][i] = fill_val(a, fill_epoch);
      end
      m_inv = (nw + 1) % 4;
      cmt_q.push_back('{nw, 1 << m_inv});
    end
    m_cwp = nw;
  endtask

  task automatic do_op(input bit s, input bit r, input logic [31:0] base);
    int kind, prev_cwp;
    bit done_wait;
    prev_cwp = m_cwp;
    model_issue(s, r, base, kind);
    Save = s; Restore = r; SpBase = base;
    @(negedge Clk);
    #1;
    chk("req_cycle_done", Done, (kind == 1) ? 1 : 0);
    tick();
    Save = 0; Restore = 0;
    chk("busy_after_req", Busy, (kind >= 2) ? 1 : 0);
    if (kind == 0) chk("collision_cwp", CWP, prev_cwp);
    done_wait = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cmt_q.size() == 0 && !pend_v && !Busy) begin
        done_wait = 1;
        break;
      end
      SpBase = $urandom;
      Save = 0; Restore = 0;
      if (cyc == 4 && Busy && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) Save = 1; else Restore = 1;
      end
      tick();
    end
    Save = 0; Restore = 0;
    if (!done_wait) fail("op_timeout");
  endtask

  task automatic apply_reset();
    Clr = 0;
    mem_q.delete(); wr_q.delete(); cmt_q.delete();
    pend_v = 0;
    m_cwp = 0; m_inv = 3;
    tick(); tick();
    Clr = 1;
    tick();
  endtask

  // Memory responder: 0..2 cycle ack wait plus occasional stray acks.
  initial begin
    int wcnt;
    MemAck = 0; MemRData = 0; wcnt = 0;
    forever begin
      @(posedge Clk);
      #1;
      MemAck = 0;
      if (!Clr) wcnt = 0;
      else if (MemReq) begin
        if (wcnt == 0) begin
          MemAck = 1;
          MemRData = fill_val(MemAddr, fill_epoch);
          wcnt = $urandom_range(0, 2);
        end else wcnt--;
      end else if ($urandom_range(0, 7) == 0) MemAck = 1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  initial begin
    forever begin
      @(negedge Clk);
      if (Clr) begin
        if (pend_v) begin
          chk("commit_cwp", CWP, pend.cwp);
          chk("commit_wim", WIM, pend.wim);
          pend_v = 0;
        end
        if (MemReq && MemAck) begin
          n_acks++;
          if (mem_q.size() == 0) fail("mem_unexpected");
          else begin
            mem_exp_t e;
            e = mem_q.pop_front();
            chk("mem_we", MemWe, e.we);
            chk("mem_addr", MemAddr, e.addr);
            if (e.we) chk("mem_wdata", MemWData, e.data);
          end
        end
        if (!RfRFE) begin
          if (wr_q.size() == 0) fail("rf_write_unexpected");
          else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            chk("rf_win", RfCwp, w.win);
            chk("rf_reg", RfRC, w.rno);
            chk("rf_data", RfRin, w.data);
          end
          rf_dut[RfCwp][RfRC[3:0]] = RfRin;
        end
        if (Done) begin
          if (cmt_q.size() == 0) fail("done_unexpected");
          else begin
            pend = cmt_q.pop_front();
            pend_v = 1;
          end
        end
      end
    end
  end

  initial begin
    int start_acks;
    bit reached;
    Save = 0; Restore = 0; SpBase = 0; Clr = 0;
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 16; i++) begin
        rf_ref[w][i] = (w == 3) ? 32'h10 + 32'(i) : $urandom;
        rf_dut[w][i] = rf_ref[w][i];
      end
    apply_reset();
    chk("rst_cwp", CWP, 0);
    chk("rst_wim", WIM, 4'b1000);
    chk("rst_busy", Busy, 0);
    chk("rst_rfe", RfRFE, 1);
    chk("rst_memreq", MemReq, 0);
    chk("rst_done", Done, 0);

    do_op(1, 0, 32'h1000);
    do_op(1, 1, 32'h2000);
    do_op(0, 1, 32'h3000);
    do_op(0, 1, 32'h3000);
    do_op(0, 1, 32'hFFFF_FFF0);
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [31:0] b;
      sel = $urandom_range(0, 9);
      b = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFE0 + ($urandom & 32'h1C) : $urandom;
      do_op(sel < 5, sel >= 4, b);
    end

    apply_reset();
`ifdef WINDOW_SPILL_FILL_STATS_EN
    chk("stats_spill_rst", SpillCnt, 0);
`endif
    start_acks = n_acks;
    begin
      int kind;
      model_issue(1, 0, 32'h4000, kind);
    end
    Save = 1; SpBase = 32'h4000;
    tick();
    Save = 0;
    reached = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (n_acks - start_acks == 7) begin
        reached = 1;
        break;
      end
      tick();
    end
    if (!reached) fail("midspill_timeout");
    tick();
    chk("midspill_memreq_pre", MemReq, 1);
    Clr = 0;
    #1;
    chk("midspill_memreq", MemReq, 0);
    chk("midspill_busy", Busy, 0);
    chk("midspill_cwp", CWP, 0);
    chk("midspill_wim", WIM, 4'b1000);
    chk("midspill_done", Done, 0);
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 16; i++) rf_ref[w][i] = rf_dut[w][i];
    apply_reset();
    chk("post_rst_cwp", CWP, 0);
    do_op(1, 0, 32'h1000);
`ifdef WINDOW_SPILL_FILL_STATS_EN
    chk("stats_spill_one", SpillCnt, 1);
`endif
    chk("final_wim", WIM, 4'b0100);
    if (mem_q.size() != 0 || wr_q.size() != 0) fail("scoreboard_leftover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
